// File: rtl/req_ack_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_ack_rr_arbiter_if
// Purpose : Bundles the level req/ack handshake between the requester agents
//           and the round-robin arbiter, together with the arbiter status.
// Signals :
//   req      [NUM_REQ-1:0]  level request per requester (agent -> arbiter)
//   ack      [NUM_REQ-1:0]  one-hot registered grant     (arbiter -> agent)
//   grant_id [ID_W-1:0]     index of current owner, valid while busy=1
//   busy                    1 while any ack bit is high
//   timeout                 1-cycle pulse when a grant is revoked
// Modports:
//   master  requester side (drives req, observes grant/status)
//   slave   arbiter side   (observes req, drives grant/status)
// ---------------------------------------------------------------------------
interface req_ack_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    input  ack,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output ack,
    output grant_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/req_ack_rr_arbiter.sv
// ---------------------------------------------------------------------------
// req_ack_rr_arbiter
// Purpose : Round-robin arbiter sharing one downstream resource between
//           NUM_REQ requesters over a level req/ack handshake. A grant is
//           issued one clock after the request is seen in IDLE, lasts while
//           the owner holds req (at most MAX_HOLD cycles), and is always
//           followed by a one-cycle GAP turnaround. An owner revoked by the
//           hold limit is blocked until it drops its request for a cycle.
// Ports   :
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high reset
//   bus   req_ack_rr_arbiter_if.slave (req in; ack, grant_id, busy, timeout
//         out, all registered)
// Parameters:
//   NUM_REQ   number of requesters, 2..16
//   MAX_HOLD  max cycles ack may stay high for one grant, >=2
// ---------------------------------------------------------------------------
module req_ack_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  req_ack_rr_arbiter_if.slave       bus
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Registered state
  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [NUM_REQ-1:0]  blocked_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [ID_W-1:0]     gid_q;
  logic                busy_q;
  logic                to_q;

  // Next-state values
  state_t              state_d;
  logic [ID_W-1:0]     ptr_d;
  logic [HOLD_W-1:0]   hold_d;
  logic [NUM_REQ-1:0]  blocked_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic [ID_W-1:0]     gid_d;
  logic                busy_d;
  logic                to_d;

  // Arbitration helpers
  logic [NUM_REQ-1:0]  eligible;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic                owner_req;
  logic                hold_limit;
  logic [ID_W-1:0]     ptr_after_owner;

  // Round-robin pick: first eligible index scanning upward from ptr_q with
  // wrap. The modulo keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    eligible  = bus.req & ~blocked_q;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Only the owner's request is observed while granting.
  assign owner_req       = bus.req[gid_q];
  assign hold_limit      = (hold_q == HOLD_W'(MAX_HOLD));
  assign ptr_after_owner = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

  // Process 1: state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      blocked_q <= '0;
      ack_q     <= '0;
      gid_q     <= '0;
      busy_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
      ack_q     <= ack_d;
      gid_q     <= gid_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
    end
  end

  // Process 2: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (!owner_req || hold_limit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Process 3: output / datapath next values (registered by process 1)
  always_comb begin
    ack_d    = ack_q;
    busy_d   = busy_q;
    gid_d    = gid_q;
    hold_d   = hold_q;
    ptr_d    = ptr_q;
    to_d     = 1'b0;
    blocked_d = blocked_q & bus.req;   // a dropped request clears its block
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ack_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          busy_d = 1'b1;
          gid_d  = win_id;
          hold_d = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ack_d  = '0;
          busy_d = 1'b0;
          ptr_d  = ptr_after_owner;
        end else if (hold_limit) begin
          // Revoke a stuck owner; it stays blocked until it releases req.
          ack_d     = '0;
          busy_d    = 1'b0;
          to_d      = 1'b1;
          blocked_d = blocked_d | ack_q;
          ptr_d     = ptr_after_owner;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        ack_d  = '0;
        busy_d = 1'b0;
      end
      default: begin
        ack_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = to_q;

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_ack_rr_arbiter
// Self-checking bench for req_ack_rr_arbiter. A transaction-level reference
// model (current owner, cycles held, turnaround pending, rotating start
// index, per-requester block flags) predicts the outputs after each edge.
// Directed scenarios cover single grant, wrap-around, full rotation,
// hold-limit revocation and asynchronous reset; a long random phase follows.
// ---------------------------------------------------------------------------
module tb_req_ack_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;

  req_ack_rr_arbiter_if #(.NUM_REQ(N)) bus ();

  req_ack_rr_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_owner;     // -1 when nobody owns the resource
  int           m_held;      // cycles the current owner has seen ack high
  bit           m_gap;       // turnaround cycle pending
  int           m_ptr;       // first index considered at the next decision
  bit           m_blk [N];
  logic [N-1:0] e_ack;
  bit           e_busy;
  bit           e_to;
  int           e_gid;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_blk[i] = 0;
    e_ack  = '0;
    e_busy = 0;
    e_to   = 0;
    e_gid  = 0;
  endtask

  // Advance the model by one rising edge that samples request vector r.
  task automatic model_step(input logic [N-1:0] r);
    e_to = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (m_owner < 0 && r[i] && !m_blk[i]) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_gap   = 1;
    end else if (m_held == MH) begin
      e_to            = 1;
      m_blk[m_owner]  = 1;
      m_ptr           = (m_owner + 1) % N;
      m_owner         = -1;
      m_gap           = 1;
    end else begin
      m_held++;
    end
    for (int i = 0; i < N; i++) if (!r[i]) m_blk[i] = 0;
    e_busy = (m_owner >= 0);
    e_ack  = '0;
    if (m_owner >= 0) begin
      e_ack[m_owner] = 1'b1;
      e_gid          = m_owner;
    end
  endtask

  task automatic compare_all();
    check("ack",      32'(bus.ack),      32'(e_ack));
    check("busy",     32'(bus.busy),     32'(e_busy));
    check("grant_id", 32'(bus.grant_id), 32'(e_gid));
    check("timeout",  32'(bus.timeout),  32'(e_to));
  endtask

  // Called aligned to a negedge: drive r, let one posedge sample it, then
  // compare on the following negedge.
  task automatic tick(input logic [N-1:0] r);
    bus.req = r;
    model_step(r);
    @(negedge clk);
    compare_all();
  endtask

  // Synchronous-looking reset spanning one rising edge, aligned to negedge.
  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] r;
    int           cnt [N];
    int           grants [$];
    int           low_runs [$];
    int           low_run;
    bit           prev_busy;
    int           n_high;
    int           n_to;

    rst     = 1'b1;
    bus.req = '0;
    model_reset();
    #1;
    check("reset_ack",     32'(bus.ack),      32'h0);
    check("reset_busy",    32'(bus.busy),     32'h0);
    check("reset_gid",     32'(bus.grant_id), 32'h0);
    check("reset_timeout", 32'(bus.timeout),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // 1: single requester, hold then release, one GAP cycle
    tick(4'b0001);
    check("t1_grant", 32'(bus.ack), 32'h1);
    tick(4'b0001);
    tick(4'b0000);
    check("t1_release", 32'(bus.ack), 32'h0);
    tick(4'b0000);
    tick(4'b0000);

    // 2: simultaneous requests from reset, then pointer wrap
    apply_reset();
    tick(4'b0101);
    check("t2_first", 32'(bus.ack), 32'h1);
    tick(4'b0100);                  // owner 0 releases
    tick(4'b0101);                  // GAP, not evaluated
    tick(4'b0101);                  // IDLE decision, pointer at 1
    check("t2_second", 32'(bus.ack), 32'h4);
    tick(4'b0001);                  // owner 2 releases
    tick(4'b0101);                  // GAP
    tick(4'b0101);                  // pointer 3 wraps to 0
    check("t2_wrap", 32'(bus.ack), 32'h1);
    tick(4'b0000);
    tick(4'b0000);

    // 3: all request, each owner releases after 2 cycles of ack
    apply_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    r         = 4'b1111;
    prev_busy = 1'b0;
    low_run   = 0;
    for (int c = 0; c < 24; c++) begin
      tick(r);
      if (bus.busy && !prev_busy) begin
        grants.push_back(int'(bus.grant_id));
        if (grants.size() > 1) low_runs.push_back(low_run);
      end
      low_run   = bus.busy ? 0 : low_run + 1;
      prev_busy = bus.busy;
      r         = 4'b1111;
      for (int i = 0; i < N; i++) begin
        cnt[i] = bus.ack[i] ? cnt[i] + 1 : 0;
        if (cnt[i] == 2) r[i] = 1'b0;
      end
    end
    check("t3_ngrants", 32'(grants.size() >= 5), 32'h1);
    if (grants.size() >= 5) begin
      check("t3_order0", 32'(grants[0]), 32'd0);
      check("t3_order1", 32'(grants[1]), 32'd1);
      check("t3_order2", 32'(grants[2]), 32'd2);
      check("t3_order3", 32'(grants[3]), 32'd3);
      check("t3_order4", 32'(grants[4]), 32'd0);
      for (int i = 0; i < 4; i++) check("t3_gap_len", 32'(low_runs[i]), 32'd2);
    end

    // 4: stuck owner revoked by hold limit, blocked until it drops req
    apply_reset();
    n_high = 0;
    n_to   = 0;
    for (int c = 0; c < 20; c++) begin
      tick(4'b0100);
      if (bus.ack[2]) n_high++;
      if (bus.timeout) n_to++;
    end
    check("t4_hold_cycles", 32'(n_high), 32'(MH));
    check("t4_timeouts",    32'(n_to),   32'd1);
    tick(4'b0000);
    tick(4'b0100);
    check("t4_regrant", 32'(bus.ack), 32'h4);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);

    // 5: asynchronous reset mid-grant; pointer restarts at 0
    tick(4'b0100);
    tick(4'b0000);                  // release 2 -> pointer 3
    tick(4'b0000);
    tick(4'b0010);
    tick(4'b0010);
    check("t5_pre_ack", 32'(bus.ack), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_ack",  32'(bus.ack),     32'h0);
    check("t5_async_busy", 32'(bus.busy),    32'h0);
    check("t5_async_to",   32'(bus.timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
    tick(4'b1010);
    check("t5_ptr_restart", 32'(bus.ack), 32'h2);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);

    // 6: random traffic with per-cycle invariant checks
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
        r = '0;
      end
      for (int i = 0; i < N; i++) begin
        // mostly long-held requests so that both releases and timeouts occur
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      end
      tick(r);
      check("onehot0",     32'($onehot0(bus.ack)),            32'h1);
      check("busy_vs_ack", 32'(bus.busy),                     32'(|bus.ack));
      check("to_ack_zero", 32'(bus.timeout && (bus.ack != 0)), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
